// File: rtl/adma_pkg.sv
// Shared ADMA constants: AXI response codes, burst types, completion status record.
package adma_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIX  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic       err;
    logic [1:0] resp;
  } cpl_stat_t;

  // EXOKAY is a success; only SLVERR/DECERR are error responses.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/adma_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through head and occupancy count.
// Push while full is accepted only when a pop happens in the same cycle.
module adma_sync_fifo #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_en, pop_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adma_as_atx_complete.sv
// Write-response completion tracker: matches B responses to issued bursts and
// reports per-DMA-transaction completion with accumulated error status.
module adma_as_atx_complete
  import adma_pkg::*;
#(
  parameter int  MST_ID_W  = 5,
  parameter int  OUTST_MAX = 8,
  localparam int OUTST_W   = $clog2(OUTST_MAX+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MST_ID_W-1:0] atx_id,
  input  logic                atx_start,
  input  logic                atx_start_last,
  output logic                atx_full,
  output logic [OUTST_W-1:0]  outst_cnt,
  input  logic [MST_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                done_vld,
  input  logic                done_rdy,
  output logic                done_err,
  output logic [1:0]          done_resp,
  output logic                ovf_err,
  output logic                id_err
);

  logic      head_last, fifo_empty, fifo_full;
  logic      bhs, id_bad, beat_bad;
  cpl_stat_t acc, done_stat;
  logic [1:0] merged_resp;

  adma_sync_fifo #(
    .DATA_W (1),
    .DEPTH  (OUTST_MAX)
  ) u_trk_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (atx_start),
    .din   (atx_start_last),
    .pop   (bhs),
    .dout  (head_last),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outst_cnt)
  );

  assign atx_full = fifo_full;

  // A final response must wait only while the single completion slot is still occupied.
  assign bready = ~fifo_empty & ~(head_last & done_vld & ~done_rdy);
  assign bhs    = bvalid & bready;

  assign id_bad   = (bid != atx_id);
  assign beat_bad = resp_is_err(bresp) | id_bad;

  // First error response wins; an ID-only error leaves resp at OKAY.
  assign merged_resp = (acc.resp != AXI_RESP_OKAY) ? acc.resp :
                       resp_is_err(bresp)          ? bresp    : AXI_RESP_OKAY;

  assign done_err  = done_stat.err;
  assign done_resp = done_stat.resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      done_stat <= '0;
      done_vld  <= 1'b0;
      ovf_err   <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      if (bhs && head_last) begin
        done_vld       <= 1'b1;
        done_stat.err  <= acc.err | beat_bad;
        done_stat.resp <= merged_resp;
        acc            <= '0;
      end else begin
        if (done_rdy) done_vld <= 1'b0;
        if (bhs) begin
          acc.err  <= acc.err | beat_bad;
          acc.resp <= merged_resp;
        end
      end
      if (atx_start && fifo_full && !bhs) ovf_err <= 1'b1;
      if (bhs && id_bad)                  id_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adma_as_atx_complete.sv
// Scoreboard bench: queue-based reference model predicts handshakes and completions;
// a separate monitor checks each accepted completion against the expected queue.
module tb_adma_as_atx_complete;

  localparam int MAXO = 8;
  localparam int IDW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] atx_id, bid;
  logic           atx_start, atx_start_last, bvalid, done_rdy;
  logic [1:0]     bresp;
  logic           atx_full, bready, done_vld, done_err, ovf_err, id_err;
  logic [3:0]     outst_cnt;
  logic [1:0]     done_resp;

  always #5 clk = ~clk;

  adma_as_atx_complete #(.MST_ID_W(IDW), .OUTST_MAX(MAXO)) dut (
    .clk(clk), .rst(rst), .atx_id(atx_id), .atx_start(atx_start),
    .atx_start_last(atx_start_last), .atx_full(atx_full), .outst_cnt(outst_cnt),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .done_vld(done_vld), .done_rdy(done_rdy), .done_err(done_err),
    .done_resp(done_resp), .ovf_err(ovf_err), .id_err(id_err)
  );

  typedef struct { bit err; bit [1:0] resp; } cpl_t;

  bit   mq[$];
  cpl_t expq[$];
  bit   m_pend, m_acc_err, m_ovf, m_iderr, armed;
  bit [1:0] m_acc_resp;
  int   n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding bursts as a queue of last flags, one pending completion slot.
  always @(negedge clk) begin
    bit eb, bhs, was_full, bad;
    cpl_t c;
    eb = (mq.size() > 0) && !(mq[0] && m_pend && !done_rdy);
    if (armed) begin
      chk("bready",    32'(bready),    32'(eb));
      chk("outst_cnt", 32'(outst_cnt), 32'(mq.size()));
      chk("atx_full",  32'(atx_full),  32'(mq.size() == MAXO));
      chk("done_vld",  32'(done_vld),  32'(m_pend));
      chk("ovf_err",   32'(ovf_err),   32'(m_ovf));
      chk("id_err",    32'(id_err),    32'(m_iderr));
    end
    if (rst) begin
      mq.delete(); expq.delete();
      m_pend = 0; m_acc_err = 0; m_acc_resp = 0; m_ovf = 0; m_iderr = 0;
    end else begin
      bhs      = bvalid && eb;
      was_full = (mq.size() == MAXO);
      if (done_rdy) m_pend = 0;
      if (bhs) begin
        bad = bresp[1] || (bid != atx_id);
        if (bid != atx_id) m_iderr = 1;
        if (m_acc_resp == 2'b00 && bresp[1]) m_acc_resp = bresp;
        m_acc_err = m_acc_err || bad;
        if (mq.pop_front()) begin
          c.err = m_acc_err; c.resp = m_acc_resp;
          expq.push_back(c);
          m_pend = 1; m_acc_err = 0; m_acc_resp = 0;
        end
      end
      if (atx_start) begin
        if (!was_full || bhs) mq.push_back(atx_start_last);
        else m_ovf = 1;
      end
    end
  end

  // Monitor: compare each accepted completion with the scoreboard head.
  always @(negedge clk) begin
    cpl_t c;
    if (armed && !rst && done_vld === 1'b1 && done_rdy) begin
      if (expq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        c = expq.pop_front();
        chk("done_err",  32'(done_err),  32'(c.err));
        chk("done_resp", 32'(done_resp), 32'(c.resp));
      end
    end
  end

  task automatic drv(input bit s, input bit l, input bit bv, input logic [IDW-1:0] id,
                     input logic [1:0] rsp, input bit rdy);
    atx_start = s; atx_start_last = l; bvalid = bv; bid = id; bresp = rsp; done_rdy = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; atx_id = 5'h03;
    atx_start = 0; atx_start_last = 0; bvalid = 0; bid = 0; bresp = 0; done_rdy = 0;
    @(posedge clk); #1;
    armed = 1;
    @(posedge clk); #1;
    rst = 0;

    // single burst, completion held until done_rdy
    drv(1,1,0,5'h03,2'b00,0); drv(0,0,0,5'h03,2'b00,0);
    drv(0,0,1,5'h03,2'b00,0); drv(0,0,0,5'h03,2'b00,0);
    drv(0,0,0,5'h03,2'b00,1); drv(0,0,0,5'h03,2'b00,0);

    // three-burst transaction with errors
    drv(1,0,0,5'h03,2'b00,1); drv(1,0,0,5'h03,2'b00,1); drv(1,1,0,5'h03,2'b00,1);
    drv(0,0,1,5'h03,2'b00,1); drv(0,0,1,5'h03,2'b10,1); drv(0,0,1,5'h03,2'b11,0);
    drv(0,0,0,5'h03,2'b00,1); drv(0,0,0,5'h03,2'b00,0);

    // back-pressure, then pop and accept in the same cycle
    drv(1,1,0,5'h03,2'b00,0); drv(1,1,0,5'h03,2'b00,0);
    drv(0,0,1,5'h03,2'b00,0);
    repeat (3) drv(0,0,1,5'h03,2'b10,0);
    drv(0,0,1,5'h03,2'b10,1); drv(0,0,0,5'h03,2'b00,1); drv(0,0,0,5'h03,2'b00,0);

    // fill, push with pop while full, then overflow
    for (int i = 0; i < MAXO; i++) drv(1,i[0],0,5'h03,2'b00,1);
    drv(1,1,1,5'h03,2'b00,1);
    drv(1,0,0,5'h03,2'b00,1);
    repeat (MAXO) drv(0,0,1,5'h03,2'b00,1);
    drv(0,0,0,5'h03,2'b00,1);

    // ID mismatch with OKAY on a last entry
    drv(1,1,0,5'h03,2'b00,1); drv(0,0,1,5'h04,2'b00,1);
    drv(0,0,0,5'h03,2'b00,1); drv(0,0,0,5'h03,2'b00,0);

    // reset mid-flight with a completion pending
    repeat (4) drv(1,1,0,5'h03,2'b00,0);
    drv(0,0,1,5'h03,2'b00,0); drv(0,0,1,5'h03,2'b00,0);
    rst = 1; drv(0,0,1,5'h03,2'b00,0);
    rst = 0; drv(0,0,1,5'h03,2'b00,0); drv(0,0,1,5'h03,2'b00,1);

    // randomized traffic, load level varying by phase
    for (int i = 0; i < 3000; i++) begin
      int ps, pb, pr;
      logic [IDW-1:0] b_id;
      logic [1:0] rsp;
      ps = (i % 900 < 300) ? 25 : (i % 900 < 600) ? 80 : 50;
      pb = (i % 900 < 300) ? 70 : (i % 900 < 600) ? 20 : 50;
      pr = ((i / 150) % 2 == 0) ? 80 : 30;
      b_id = ($urandom_range(0, 11) == 0) ? atx_id + 5'd1 : atx_id;
      case ($urandom_range(0, 4))
        3: rsp = 2'b10;
        4: rsp = 2'b11;
        default: rsp = 2'b00;
      endcase
      if ($urandom_range(0, 399) == 0) begin
        rst = 1; drv(0,0,1,atx_id,2'b00,0);
        rst = 0; atx_id = IDW'($urandom);
      end else begin
        drv($urandom_range(0,99) < ps, $urandom_range(0,2) == 0,
            $urandom_range(0,99) < pb, b_id, rsp, $urandom_range(0,99) < pr);
      end
    end
    repeat (4) drv(0,0,0,atx_id,2'b00,1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
